// File: rtl/key_pkg.sv
// key_pkg
// Shared definitions for the push-button conditioning slice.
//   key_state_t      : per-key debounce FSM state encoding
//   DB_COUNT_DEFAULT : default stable-sample count (10 ms at 50 MHz)
//   DB_COUNT_MAX     : largest legal stable-sample count
//   CNT_W            : debounce counter width, wide enough for DB_COUNT_MAX-1
package key_pkg;

  typedef enum logic [1:0] {
    KEY_RELEASED     = 2'd0,
    KEY_PRESS_WAIT   = 2'd1,
    KEY_PRESSED      = 2'd2,
    KEY_RELEASE_WAIT = 2'd3
  } key_state_t;

  localparam int DB_COUNT_DEFAULT = 500000;
  localparam int DB_COUNT_MAX     = 1 << 20;
  localparam int CNT_W            = $clog2(DB_COUNT_MAX);

endpackage

// File: rtl/key_debounce.sv
// key_debounce
// Conditions one raw active-low push button: two-flop synchronizer,
// inversion to active-high, then a four-state debounce FSM with a
// stable-sample counter.
// Ports:
//   Clock  in  : rising-edge system clock
//   Reset  in  : asynchronous active-high reset
//   key_n  in  : raw button level, active-low, asynchronous to Clock
//   level  out : registered debounced level, 1 while PRESSED/RELEASE_WAIT
//   rise   out : high during the cycle whose closing edge accepts a press
//                (PRESS_WAIT -> PRESSED); the parent registers it so the
//                strobe lands on the same edge the FSM enters PRESSED
module key_debounce
  import key_pkg::*;
#(
  parameter int DB_COUNT = DB_COUNT_DEFAULT
) (
  input  logic Clock,
  input  logic Reset,
  input  logic key_n,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_COUNT - 1);

  logic             sync1;
  logic             sync2;
  logic             sample;
  logic             done;
  key_state_t       state;
  logic [CNT_W-1:0] cnt;

  // Synchronizer resets to the released raw level (1) so a key held
  // through reset is seen as a fresh press once reset drops.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  assign sample = ~sync2;
  assign done   = (cnt == LAST);
  assign rise   = (state == KEY_PRESS_WAIT) && sample && done;

  // Debounce FSM: a level change is accepted only after DB_COUNT
  // consecutive agreeing samples; any disagreeing sample falls back to
  // the previous stable state and restarts the count.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= KEY_RELEASED;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      case (state)
        KEY_RELEASED: begin
          if (sample) begin
            state <= KEY_PRESS_WAIT;
            cnt   <= '0;
          end
        end
        KEY_PRESS_WAIT: begin
          if (!sample) begin
            state <= KEY_RELEASED;
            cnt   <= '0;
          end else if (done) begin
            state <= KEY_PRESSED;
            level <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        KEY_PRESSED: begin
          if (!sample) begin
            state <= KEY_RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        KEY_RELEASE_WAIT: begin
          if (sample) begin
            state <= KEY_PRESSED;
            cnt   <= '0;
          end else if (done) begin
            state <= KEY_RELEASED;
            level <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= KEY_RELEASED;
          cnt   <= '0;
          level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner
// Debounces four push buttons and turns accepted KEY0 presses into an
// execute strobe carrying the function code held on KEY3..KEY1.
// Ports:
//   Clock       in  : rising-edge system clock
//   Reset       in  : asynchronous active-high reset
//   KEY_n       in  : raw buttons, active-low
//   pressed     out : debounced levels, active-high
//   op_sel      out : pressed[3:1] captured at each accepted KEY0 press
//   op_strobe   out : one-cycle execute pulse per accepted KEY0 press
//   press_count out : op_strobe pulses since reset, modulo 256
module key_conditioner
  import key_pkg::*;
#(
  parameter int DB_COUNT = DB_COUNT_DEFAULT
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] KEY_n,
  output logic [3:0] pressed,
  output logic [2:0] op_sel,
  output logic       op_strobe,
  output logic [7:0] press_count
);

  logic       exec_rise;
  logic [2:0] fn_rise_unused;

  key_debounce #(.DB_COUNT(DB_COUNT)) u_key0 (
    .Clock (Clock),
    .Reset (Reset),
    .key_n (KEY_n[0]),
    .level (pressed[0]),
    .rise  (exec_rise)
  );

  // Function keys only contribute their levels; their press edges are
  // not used.
  for (genvar i = 1; i < 4; i++) begin : g_fn_key
    key_debounce #(.DB_COUNT(DB_COUNT)) u_key (
      .Clock (Clock),
      .Reset (Reset),
      .key_n (KEY_n[i]),
      .level (pressed[i]),
      .rise  (fn_rise_unused[i-1])
    );
  end

  // Strobe, opcode capture and count all fire on the edge where key 0
  // enters PRESSED; op_sel takes the function-key levels from before
  // that edge and holds until the next accepted press.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      op_sel      <= '0;
      op_strobe   <= 1'b0;
      press_count <= '0;
    end else begin
      op_strobe <= exec_rise;
      if (exec_rise) begin
        op_sel      <= pressed[3:1];
        press_count <= press_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner
// Directed bench for key_conditioner with DB_COUNT = 4. Each accepted
// press is predicted when the stimulus is driven (edge, op_sel, count)
// and pushed to a queue; a negedge monitor pops and compares on every
// op_strobe. A strobe with nothing queued is an error.
module tb_key_conditioner;

  localparam int DB = 4;

  typedef struct {
    int         cyc;
    logic [2:0] sel;
    logic [7:0] cnt;
  } exp_t;

  logic       Clock;
  logic       Reset;
  logic [3:0] KEY_n;
  logic [3:0] pressed;
  logic [2:0] op_sel;
  logic       op_strobe;
  logic [7:0] press_count;

  int         tests;
  int         fails;
  int         edge_cnt;
  int         strobes_seen;
  logic [7:0] model_count;
  exp_t       sb[$];

  key_conditioner #(.DB_COUNT(DB)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .KEY_n       (KEY_n),
    .pressed     (pressed),
    .op_sel      (op_sel),
    .op_strobe   (op_strobe),
    .press_count (press_count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Rising edges since time zero; strobe timing is judged against it.
  always @(posedge Clock) edge_cnt++;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    assert (actual === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drive the keys at a falling edge and stay for a number of cycles.
  task automatic applyStimulus(input logic [3:0] keys, input int cycles);
    KEY_n = keys;
    repeat (cycles) @(negedge Clock);
  endtask

  // Predict a key-0 press driven now: edge 1 of the synchronizer is the
  // next rising edge, so the strobe follows edge_cnt + 1 + DB + 2.
  task automatic pushPress(input logic [2:0] sel, input int extra);
    exp_t e;
    model_count = model_count + 8'd1;
    e.cyc = edge_cnt + DB + 3 + extra;
    e.sel = sel;
    e.cnt = model_count;
    sb.push_back(e);
  endtask

  // Scoreboard consumer.
  always @(negedge Clock) begin
    if (op_strobe) begin
      strobes_seen++;
      tests++;
      assert (sb.size() != 0)
      else begin
        fails++;
        $error("[TB] FAIL unexpected_strobe: op_strobe=1 at edge %0d, expected 0", edge_cnt);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("strobe_edge", edge_cnt, e.cyc);
        checkOutput("strobe_op_sel", {29'd0, op_sel}, {29'd0, e.sel});
        checkOutput("strobe_press_count", {24'd0, press_count}, {24'd0, e.cnt});
      end
    end
  end

  initial begin
    tests        = 0;
    fails        = 0;
    edge_cnt     = 0;
    strobes_seen = 0;
    model_count  = 8'd0;
    Reset        = 1'b1;
    KEY_n        = 4'hF;

    // Reset state
    repeat (3) @(negedge Clock);
    checkOutput("rst_pressed", {28'd0, pressed}, 32'd0);
    checkOutput("rst_op_sel", {29'd0, op_sel}, 32'd0);
    checkOutput("rst_op_strobe", {31'd0, op_strobe}, 32'd0);
    checkOutput("rst_press_count", {24'd0, press_count}, 32'd0);
    Reset = 1'b0;
    applyStimulus(4'hF, 3);

    // Clean press of key 0, strobe after edge 7
    KEY_n = 4'b1110;
    pushPress(3'b000, 0);
    applyStimulus(4'b1110, 12);
    checkOutput("clean_pressed", {28'd0, pressed}, 32'h1);
    checkOutput("clean_queue_empty", sb.size(), 32'd0);
    applyStimulus(4'hF, 12);
    checkOutput("clean_released", {28'd0, pressed}, 32'h0);

    // Bounce: low edges 1-4, high edge 5, low from edge 6 -> strobe after edge 12
    KEY_n = 4'b1110;
    pushPress(3'b000, 5);
    applyStimulus(4'b1110, 4);
    applyStimulus(4'b1111, 1);
    applyStimulus(4'b1110, 14);
    checkOutput("bounce_pressed", {28'd0, pressed}, 32'h1);
    checkOutput("bounce_queue_empty", sb.size(), 32'd0);
    applyStimulus(4'hF, 12);

    // Op capture: KEY_n[3:1] = 010 -> pressed[3:1] = 101
    applyStimulus(4'b0101, 10);
    checkOutput("opcap_fn_levels", {28'd0, pressed}, 32'hA);
    KEY_n = 4'b0100;
    pushPress(3'b101, 0);
    applyStimulus(4'b0100, 12);
    checkOutput("opcap_pressed", {28'd0, pressed}, 32'hB);
    checkOutput("opcap_op_sel", {29'd0, op_sel}, 32'h5);
    applyStimulus(4'hF, 15);
    checkOutput("opcap_all_released", {28'd0, pressed}, 32'h0);
    checkOutput("opcap_op_sel_hold", {29'd0, op_sel}, 32'h5);
    checkOutput("opcap_queue_empty", sb.size(), 32'd0);

    // Release bounce while held: no extra strobe, level stays up
    KEY_n = 4'b1110;
    pushPress(3'b000, 0);
    applyStimulus(4'b1110, 12);
    checkOutput("relb_op_sel", {29'd0, op_sel}, 32'h0);
    KEY_n = 4'hF;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clock);
      checkOutput("relb_level_high_phase", {31'd0, pressed[0]}, 32'd1);
    end
    KEY_n = 4'b1110;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      checkOutput("relb_level_low_phase", {31'd0, pressed[0]}, 32'd1);
    end
    checkOutput("relb_queue_empty", sb.size(), 32'd0);
    checkOutput("relb_press_count", {24'd0, press_count}, 32'd4);
    applyStimulus(4'hF, 12);
    checkOutput("relb_released", {28'd0, pressed}, 32'h0);

    // Reset mid-debounce: pending press abandoned, held key re-detected
    applyStimulus(4'b1110, 3);
    Reset = 1'b1;
    #1;
    checkOutput("midrst_pressed", {28'd0, pressed}, 32'd0);
    checkOutput("midrst_op_sel", {29'd0, op_sel}, 32'd0);
    checkOutput("midrst_op_strobe", {31'd0, op_strobe}, 32'd0);
    checkOutput("midrst_press_count", {24'd0, press_count}, 32'd0);
    checkOutput("midrst_queue_empty", sb.size(), 32'd0);
    model_count = 8'd0;
    @(negedge Clock);
    Reset = 1'b0;
    pushPress(3'b000, 0);
    applyStimulus(4'b1110, 12);
    checkOutput("midrst_repress_level", {28'd0, pressed}, 32'h1);
    checkOutput("midrst_queue_empty_after", sb.size(), 32'd0);
    applyStimulus(4'hF, 12);

    // Wrap: 256 press/release cycles from a fresh reset
    Reset = 1'b1;
    @(negedge Clock);
    Reset        = 1'b0;
    model_count  = 8'd0;
    strobes_seen = 0;
    for (int n = 0; n < 256; n++) begin
      KEY_n = 4'b1110;
      pushPress(3'b000, 0);
      applyStimulus(4'b1110, 10);
      applyStimulus(4'hF, 10);
    end
    checkOutput("wrap_strobes", strobes_seen, 32'd256);
    checkOutput("wrap_press_count", {24'd0, press_count}, 32'd0);
    checkOutput("wrap_queue_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
